// File: rtl/keypad_pkg.sv
// Shared key codes, opcode encoding and token layout for the keypad token decoder.
package keypad_pkg;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_NOP       = 4'hA;
  localparam logic [3:0] KEY_ADD       = 4'hB;
  localparam logic [3:0] KEY_SUB       = 4'hC;
  localparam logic [3:0] KEY_ENTER     = 4'hD;
  localparam logic [3:0] KEY_CLR       = 4'hE;
  localparam logic [3:0] KEY_BAD       = 4'hF;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_ENTER = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    KC_DIGIT,
    KC_OP,
    KC_CLR,
    KC_BAD
  } key_class_t;

  localparam int TOK_DATA_W = 8;

  typedef struct packed {
    op_t                   op;
    logic                  ovf;
    logic [TOK_DATA_W-1:0] data;
  } token_t;

  function automatic key_class_t classify(input logic [3:0] k);
    if (k <= KEY_DIGIT_MAX) return KC_DIGIT;
    if (k == KEY_CLR)       return KC_CLR;
    if (k == KEY_BAD)       return KC_BAD;
    return KC_OP;
  endfunction

  // Opcode keys 0xA..0xD map to 0..3; the low two bits minus 2 give that mod 4.
  function automatic op_t key_to_op(input logic [1:0] k_lo);
    return op_t'(k_lo - 2'b10);
  endfunction

endpackage

// File: rtl/keypad_token_decoder_fifo.sv
// First-word-fall-through token FIFO with simultaneous push/pop allowed when full.
module token_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot the push needs, so a full FIFO still accepts.
  always_comb begin
    rd_en    = pop & ~empty;
    wr_en    = push & (~full | rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/keypad_token_decoder.sv
// Keypad strobe synchroniser, decimal operand accumulator and opcode token producer.
module keypad_token_decoder
  import keypad_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_strobe,
  input  logic [3:0]               in,
  output logic                     tok_valid,
  input  logic                     tok_ready,
  output logic [1:0]               tok_op,
  output logic [DATA_W-1:0]        tok_data,
  output logic                     tok_ovf,
  output logic                     is_op,
  output logic                     key_err,
  output logic                     overrun,
  output logic [$clog2(DEPTH):0]   count
);

  typedef struct packed {
    op_t               op;
    logic              ovf;
    logic [DATA_W-1:0] data;
  } tok_t;

  localparam int TOK_W = $bits(tok_t);

  // Returns {saturated, value} for acc*10 + d evaluated four bits wider than the operand.
  function automatic logic [DATA_W:0] sat_digit(input logic [DATA_W-1:0] acc,
                                                input logic [3:0]        d);
    logic [DATA_W+3:0] wide;
    wide = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{DATA_W{1'b0}}, d};
    if (wide[DATA_W+3:DATA_W] != 4'b0000) return {1'b1, {DATA_W{1'b1}}};
    return {1'b0, wide[DATA_W-1:0]};
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_dly_q, sync_dly_d;
  logic [DATA_W-1:0]      acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic                   is_op_q, is_op_d;
  logic                   key_err_q, key_err_d;
  logic                   overrun_q, overrun_d;

  logic                   evt;
  key_class_t             cls;
  logic [DATA_W:0]        digit_res;
  logic                   push_req, pop_req, push_refused;
  logic                   fifo_full, fifo_empty;
  tok_t                   wr_tok, head_tok;

  assign sync_d     = {sync_q[SYNC_STAGES-2:0], key_strobe};
  assign sync_dly_d = sync_q[SYNC_STAGES-1];
  assign evt        = sync_q[SYNC_STAGES-1] & ~sync_dly_q;

  assign cls       = classify(in);
  assign digit_res = sat_digit(acc_q, in);

  assign tok_valid    = ~fifo_empty;
  assign pop_req      = tok_valid & tok_ready;
  assign push_req     = evt & (cls == KC_OP);
  assign push_refused = push_req & fifo_full & ~pop_req;

  assign wr_tok.op   = key_to_op(in[1:0]);
  assign wr_tok.ovf  = ovf_q;
  assign wr_tok.data = acc_q;

  always_comb begin
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    is_op_d   = 1'b0;
    key_err_d = 1'b0;
    overrun_d = 1'b0;
    if (evt) begin
      case (cls)
        KC_DIGIT: begin
          acc_d = digit_res[DATA_W-1:0];
          ovf_d = ovf_q | digit_res[DATA_W];
        end
        KC_OP: begin
          is_op_d = 1'b1;
          // A refused token keeps the operand so the user can retry once the FIFO drains.
          if (push_refused) begin
            overrun_d = 1'b1;
          end else begin
            acc_d = '0;
            ovf_d = 1'b0;
          end
        end
        KC_CLR: begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        default: key_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      is_op_q    <= 1'b0;
      key_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      sync_dly_q <= sync_dly_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      is_op_q    <= is_op_d;
      key_err_q  <= key_err_d;
      overrun_q  <= overrun_d;
    end
  end

  token_fifo #(
    .WIDTH (TOK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push_req),
    .wdata (wr_tok),
    .pop   (pop_req),
    .rdata (head_tok),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // Head fields are forced to zero while the FIFO is empty.
  assign tok_op   = tok_valid ? head_tok.op   : 2'b00;
  assign tok_ovf  = tok_valid ? head_tok.ovf  : 1'b0;
  assign tok_data = tok_valid ? head_tok.data : '0;

  assign is_op   = is_op_q;
  assign key_err = key_err_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_keypad_token_decoder.sv
// Scoreboard bench for keypad_token_decoder: stimulus queues expected tokens, a monitor checks pops.
module tb_keypad_token_decoder;

  localparam int DATA_W      = 8;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_strobe = 1'b0;
  logic [3:0]  in = 4'h0;
  logic        tok_ready = 1'b0;
  logic        tok_valid, tok_ovf, is_op, key_err, overrun;
  logic [1:0]  tok_op;
  logic [7:0]  tok_data;
  logic [2:0]  count;

  typedef struct packed {
    logic [1:0] op;
    logic       ovf;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks  = 0;
  int n_fail    = 0;
  int n_is_op   = 0;
  int n_key_err = 0;
  int n_overrun = 0;

  keypad_token_decoder #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_strobe (key_strobe),
    .in         (in),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready),
    .tok_op     (tok_op),
    .tok_data   (tok_data),
    .tok_ovf    (tok_ovf),
    .is_op      (is_op),
    .key_err    (key_err),
    .overrun    (overrun),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_tok(input logic [1:0] op, input logic [7:0] data, input logic ovf);
    exp_t e;
    e.op   = op;
    e.ovf  = ovf;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: pulse counters and token checks on every accepted pop.
  always @(negedge clk) begin
    if (is_op)   n_is_op++;
    if (key_err) n_key_err++;
    if (overrun) n_overrun++;
    if (tok_valid && tok_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_token: got op=%0d data=%0d ovf=%0d, expected none",
                 tok_op, tok_data, tok_ovf);
      end else begin
        mon_e = sb.pop_front();
        check("pop_op",   tok_op,   mon_e.op);
        check("pop_data", tok_data, mon_e.data);
        check("pop_ovf",  tok_ovf,  mon_e.ovf);
      end
    end
  end

  task automatic press(input logic [3:0] k);
    @(posedge clk);
    #1 in = k;
    key_strobe = 1'b1;
    repeat (4) @(posedge clk);
    #1 key_strobe = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Raise tok_ready only for the cycle in which the key event is expected.
  task automatic press_with_pop(input logic [3:0] k);
    @(posedge clk);
    #1 in = k;
    key_strobe = 1'b1;
    repeat (2) @(posedge clk);
    #1 tok_ready = 1'b1;
    @(posedge clk);
    #1 tok_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 key_strobe = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    @(posedge clk);
    #1 tok_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (!tok_valid) break;
    end
    tok_ready = 1'b0;
    check("drain_valid", tok_valid, 0);
    check("drain_count", count, 0);
    check("drain_sb_left", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int iop0, ke0, ov0;

    // Reset asserted while a strobe is active
    rst = 1'b0;
    in = 4'h3;
    key_strobe = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", tok_valid, 0);
    check("rst_op", tok_op, 0);
    check("rst_data", tok_data, 0);
    check("rst_ovf", tok_ovf, 0);
    check("rst_is_op", is_op, 0);
    check("rst_key_err", key_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_count", count, 0);
    @(posedge clk);
    #1 key_strobe = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("release_pulses", n_is_op + n_key_err + n_overrun, 0);
    check("release_valid", tok_valid, 0);

    // 1 2 3 ADD held at the head
    press(4'h1); press(4'h2); press(4'h3); press(4'hB);
    check("t2_is_op", n_is_op, 1);
    check("t2_valid", tok_valid, 1);
    check("t2_op", tok_op, 1);
    check("t2_data", tok_data, 123);
    check("t2_ovf", tok_ovf, 0);
    check("t2_count", count, 1);
    expect_tok(2'b01, 8'd123, 1'b0);

    // 9 9 9 SUB saturates; the following token starts clean
    press(4'h9); press(4'h9); press(4'h9); press(4'hC);
    expect_tok(2'b10, 8'd255, 1'b1);
    check("t3_count", count, 2);
    press(4'h5); press(4'hA);
    expect_tok(2'b00, 8'd5, 1'b0);
    check("t3_count2", count, 3);
    drain();

    // Five ENTERs into a four-entry FIFO
    ov0 = n_overrun;
    iop0 = n_is_op;
    for (int i = 0; i < 5; i++) press(4'hD);
    for (int i = 0; i < 4; i++) expect_tok(2'b11, 8'd0, 1'b0);
    check("t4_count", count, 4);
    check("t4_overrun", n_overrun - ov0, 1);
    check("t4_is_op", n_is_op - iop0, 5);
    drain();

    // Full FIFO with a pop coinciding with the opcode event
    for (int i = 1; i <= 4; i++) begin
      press(4'(i));
      press(4'hA);
      expect_tok(2'b00, 8'(i), 1'b0);
    end
    check("t5_full_count", count, 4);
    press(4'h7);
    ov0 = n_overrun;
    press_with_pop(4'hD);
    expect_tok(2'b11, 8'd7, 1'b0);
    check("t5_count", count, 4);
    check("t5_overrun", n_overrun - ov0, 0);
    check("t5_sb_left", sb.size(), 4);
    drain();

    // CLEAR discards, illegal key only flags an error
    ke0 = n_key_err;
    iop0 = n_is_op;
    press(4'h5); press(4'hE); press(4'h7); press(4'hA); press(4'hF);
    check("t6_data", tok_data, 7);
    check("t6_op", tok_op, 0);
    check("t6_ovf", tok_ovf, 0);
    check("t6_key_err", n_key_err - ke0, 1);
    check("t6_is_op", n_is_op - iop0, 1);
    expect_tok(2'b00, 8'd7, 1'b0);
    drain();

    // Strobe held high for ten cycles is one digit
    @(posedge clk);
    #1 in = 4'h8;
    key_strobe = 1'b1;
    repeat (10) @(posedge clk);
    #1 key_strobe = 1'b0;
    repeat (4) @(posedge clk);
    press(4'hA);
    check("held_data", tok_data, 8);
    expect_tok(2'b00, 8'd8, 1'b0);
    drain();

    // Reset mid-entry drops queued tokens and the partial operand
    press(4'h6); press(4'hA);
    press(4'h4); press(4'h5);
    check("mid_count_before", count, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", tok_valid, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    iop0 = n_is_op;
    ke0 = n_key_err;
    ov0 = n_overrun;
    repeat (6) @(posedge clk);
    #1;
    check("mid_release_pulses", (n_is_op - iop0) + (n_key_err - ke0) + (n_overrun - ov0), 0);
    press(4'hA);
    check("mid_valid", tok_valid, 1);
    check("mid_data", tok_data, 0);
    expect_tok(2'b00, 8'd0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
